// File: rtl/axi4_lite_apb_bridge_fe_if.sv
// Bus bundle between an AXI4-Lite master and the APB request front-end.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R) and the APB
// request/completion control set (transfer/read/write, addresses, data,
// strobes, apb_done/apb_error).
//   modport slave  : the bridge side (accepts AXI, issues APB requests)
//   modport master : the environment side (AXI master plus APB completer)
interface axi4_lite_apb_bridge_fe_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    logic                  transfer;
    logic                  read;
    logic                  write;
    logic [STRB_WIDTH-1:0] apb_wstrb;
    logic [ADDR_WIDTH-1:0] apb_waddr;
    logic [ADDR_WIDTH-1:0] apb_raddr;
    logic [DATA_WIDTH-1:0] apb_wdata;
    logic [DATA_WIDTH-1:0] apb_rdata;
    logic                  apb_done;
    logic                  apb_error;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY, apb_rdata, apb_done, apb_error,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
               transfer, read, write, apb_wstrb, apb_waddr, apb_raddr, apb_wdata
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY, apb_rdata, apb_done, apb_error,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
               transfer, read, write, apb_wstrb, apb_waddr, apb_raddr, apb_wdata
    );
endinterface

// File: rtl/axi4_lite_apb_bridge_fe.sv
// AXI4-Lite slave front-end for the APB subsystem. Each accepted AXI
// transaction becomes one APB request; the response is returned once the
// APB side signals apb_done. Only one APB access is in flight at a time,
// while each of AW/W/AR keeps a one-entry holder so the next request can be
// accepted during the current one.
// Ports:
//   PCLK    : clock
//   PRESETn : asynchronous active-low reset
//   bus     : axi4_lite_apb_bridge_fe_if.slave (AXI channels + APB request set)
// Optional build macro APB_TIMEOUT_EN: adds a watchdog that forces a SLVERR
// response after TIMEOUT_CYCLES cycles in a WAIT state without apb_done.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no APB access; arbitrate between ready write and read
// WR_REQ  | one-cycle transfer pulse with write=1
// WR_WAIT | write held, waiting for apb_done (or watchdog)
// WR_RESP | BVALID held until BREADY
// RD_REQ  | one-cycle transfer pulse with read=1
// RD_WAIT | read held, waiting for apb_done (or watchdog)
// RD_RESP | RVALID held until RREADY
module axi4_lite_apb_bridge_fe #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic PCLK,
    input  logic PRESETn,
    axi4_lite_apb_bridge_fe_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 2 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
        $error("axi4_lite_apb_bridge_fe: TIMEOUT_CYCLES must be >= 2 and DATA_WIDTH a multiple of 8");
    end

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
    } state_t;

    state_t state_q, state_d;

    logic                  rst_done_q;
    logic                  aw_full_q, w_full_q, ar_full_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  rr_rd_q;
    logic [ADDR_WIDTH-1:0] apb_waddr_q, apb_raddr_q;
    logic [DATA_WIDTH-1:0] apb_wdata_q, rdata_q;
    logic [STRB_WIDTH-1:0] apb_wstrb_q;
    logic [1:0]            bresp_q, rresp_q;

    logic aw_hs, w_hs, ar_hs;
    logic wr_rdy, rd_rdy;
    logic launch_wr, launch_rd;
    logic in_wait;
    logic tmo_hit;

    // READY is held low until the first clock after reset release so that
    // every output is 0 while PRESETn is asserted.
    assign bus.AWREADY = rst_done_q & ~aw_full_q;
    assign bus.WREADY  = rst_done_q & ~w_full_q;
    assign bus.ARREADY = rst_done_q & ~ar_full_q;

    assign aw_hs = bus.AWVALID & bus.AWREADY;
    assign w_hs  = bus.WVALID  & bus.WREADY;
    assign ar_hs = bus.ARVALID & bus.ARREADY;

    // A handshake in this cycle counts as present so IDLE can launch
    // without first parking the request in its holder.
    assign wr_rdy = (aw_full_q | aw_hs) & (w_full_q | w_hs);
    assign rd_rdy = ar_full_q | ar_hs;

    assign in_wait = (state_q == WR_WAIT) || (state_q == RD_WAIT);

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WR_REQ || state_q == RD_REQ) begin
            tmo_cnt_q <= '0;
        end else if (in_wait) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = in_wait && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        launch_wr = 1'b0;
        launch_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_rdy && (!wr_rdy || rr_rd_q)) begin
                    launch_rd = 1'b1;
                    state_d   = RD_REQ;
                end else if (wr_rdy) begin
                    launch_wr = 1'b1;
                    state_d   = WR_REQ;
                end
            end
            WR_REQ:  state_d = WR_WAIT;
            WR_WAIT: if (bus.apb_done || tmo_hit) state_d = WR_RESP;
            WR_RESP: if (bus.BREADY) state_d = IDLE;
            RD_REQ:  state_d = RD_WAIT;
            RD_WAIT: if (bus.apb_done || tmo_hit) state_d = RD_RESP;
            RD_RESP: if (bus.RREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.transfer  = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign bus.write     = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign bus.read      = (state_q == RD_REQ) || (state_q == RD_WAIT);
    assign bus.BVALID    = (state_q == WR_RESP);
    assign bus.RVALID    = (state_q == RD_RESP);
    assign bus.BRESP     = bresp_q;
    assign bus.RRESP     = rresp_q;
    assign bus.RDATA     = rdata_q;
    assign bus.apb_waddr = apb_waddr_q;
    assign bus.apb_wdata = apb_wdata_q;
    assign bus.apb_wstrb = apb_wstrb_q;
    assign bus.apb_raddr = apb_raddr_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rst_done_q  <= 1'b0;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            ar_full_q   <= 1'b0;
            aw_addr_q   <= '0;
            ar_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            rr_rd_q     <= 1'b1;
            apb_waddr_q <= '0;
            apb_wdata_q <= '0;
            apb_wstrb_q <= '0;
            apb_raddr_q <= '0;
            bresp_q     <= 2'b00;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
        end else begin
            rst_done_q <= 1'b1;

            if (launch_wr)  aw_full_q <= 1'b0;
            else if (aw_hs) aw_full_q <= 1'b1;
            if (launch_wr)  w_full_q  <= 1'b0;
            else if (w_hs)  w_full_q  <= 1'b1;
            if (launch_rd)  ar_full_q <= 1'b0;
            else if (ar_hs) ar_full_q <= 1'b1;

            if (aw_hs) aw_addr_q <= bus.AWADDR;
            if (ar_hs) ar_addr_q <= bus.ARADDR;
            if (w_hs) begin
                w_data_q <= bus.WDATA;
                w_strb_q <= bus.WSTRB;
            end

            if (launch_wr) begin
                apb_waddr_q <= aw_full_q ? aw_addr_q : bus.AWADDR;
                apb_wdata_q <= w_full_q  ? w_data_q  : bus.WDATA;
                apb_wstrb_q <= w_full_q  ? w_strb_q  : bus.WSTRB;
            end
            if (launch_rd) begin
                apb_raddr_q <= ar_full_q ? ar_addr_q : bus.ARADDR;
            end

            // Priority moves to the losing type only when both contended.
            if (launch_rd && wr_rdy)      rr_rd_q <= 1'b0;
            else if (launch_wr && rd_rdy) rr_rd_q <= 1'b1;

            if (state_q == WR_WAIT) begin
                if (bus.apb_done)  bresp_q <= bus.apb_error ? 2'b10 : 2'b00;
                else if (tmo_hit)  bresp_q <= 2'b10;
            end
            if (state_q == RD_WAIT) begin
                if (bus.apb_done) begin
                    rdata_q <= bus.apb_rdata;
                    rresp_q <= bus.apb_error ? 2'b10 : 2'b00;
                end else if (tmo_hit) begin
                    rdata_q <= '0;
                    rresp_q <= 2'b10;
                end
            end
        end
    end
endmodule
